// File: rtl/mux2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_pkg
//  Purpose  : Shared constants and lock-state encoding for the 2:1 stream
//             merger (mux2_stream_arb) and its round-robin arbiter.
//  Options  : MUX2_PKT_LOCK_EN selects per-packet arbitration in rr_arb2.
//  Revision : 1.0  initial release
// ============================================================================
package mux2_pkg;

   localparam int   W_DEFAULT = 8;

   localparam logic SRC_I0 = 1'b0;
   localparam logic SRC_I1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } lock_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-requester round-robin arbiter. gnt is combinational and
//             one-hot (or zero); en marks a completed transfer from the
//             granted requester, lock_req says that beat is not the last of
//             its packet.
//  Options  : MUX2_PKT_LOCK_EN - hold the grant on one requester for the
//             whole packet; pointer advances only on the last beat.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2
   import mux2_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   input  logic       lock_req,
   output logic [1:0] gnt
);

   logic       ptr_q, ptr_d;
   logic [1:0] elig;
   logic       gnt_src;

   assign gnt_src = gnt[1] ? SRC_I1 : SRC_I0;

`ifdef MUX2_PKT_LOCK_EN
   lock_state_e state_q, state_d;

   // While a packet owns the lane, only its source may be granted.
   always_comb begin
      elig = req;
      case (state_q)
         LOCK0:   elig = req & 2'b01;
         LOCK1:   elig = req & 2'b10;
         default: elig = req;
      endcase
   end

   // Lock FSM and pointer: both move only on packet boundaries.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (en) begin
         case (state_q)
            IDLE: begin
               if (lock_req) state_d = (gnt_src == SRC_I1) ? LOCK1 : LOCK0;
            end
            LOCK0, LOCK1: begin
               if (!lock_req) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
         if (!lock_req) ptr_d = ~gnt_src;
      end
   end

   // Lock state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end
`else
   logic unused_lock_req;
   assign unused_lock_req = lock_req;

   // Every beat competes independently.
   always_comb begin
      elig = req;
   end

   // Pointer favours the other source after every transfer.
   always_comb begin
      ptr_d = ptr_q;
      if (en) ptr_d = ~gnt_src;
   end
`endif

   // Single eligible requester wins outright; a tie goes to the pointer.
   always_comb begin
      gnt = 2'b00;
      case (elig)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // Round-robin pointer register; reset favours source 0.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= SRC_I0;
      else     ptr_q <= ptr_d;
   end

endmodule
`default_nettype wire

// File: rtl/mux2_stream_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_stream_arb
//  Purpose  : 2:1 valid/ready stream merger with round-robin arbitration and
//             a registered output; y_sel tags each beat with its source.
//  Options  : MUX2_PKT_LOCK_EN - arbitrate per packet instead of per beat.
//  Revision : 1.0  initial release
// ============================================================================
module mux2_stream_arb
   import mux2_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i0_data,
   input  logic         i0_valid,
   input  logic         i0_last,
   output logic         i0_ready,
   input  logic [W-1:0] i1_data,
   input  logic         i1_valid,
   input  logic         i1_last,
   output logic         i1_ready,
   output logic [W-1:0] y_data,
   output logic         y_valid,
   output logic         y_last,
   output logic         y_sel,
   input  logic         y_ready
);

   logic [W-1:0] y_data_q, y_data_d;
   logic         y_valid_q, y_valid_d;
   logic         y_last_q, y_last_d;
   logic         y_sel_q, y_sel_d;

   logic         ld;
   logic [1:0]   gnt;
   logic         xfer;
   logic         lock_req;

   // Output register can take a beat when empty or being drained this cycle.
   assign ld       = !y_valid_q | y_ready;
   assign i0_ready = ld & gnt[0];
   assign i1_ready = ld & gnt[1];
   assign xfer     = ld & (gnt[0] | gnt[1]);
   assign lock_req = gnt[1] ? !i1_last : !i0_last;

   rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      ({i1_valid, i0_valid}),
      .en       (xfer),
      .lock_req (lock_req),
      .gnt      (gnt)
   );

   // Load the granted beat; an idle load cycle only clears valid.
   always_comb begin
      y_data_d  = y_data_q;
      y_valid_d = y_valid_q;
      y_last_d  = y_last_q;
      y_sel_d   = y_sel_q;
      if (ld) begin
         y_valid_d = xfer;
         if (gnt[1]) begin
            y_data_d = i1_data;
            y_last_d = i1_last;
            y_sel_d  = SRC_I1;
         end else if (gnt[0]) begin
            y_data_d = i0_data;
            y_last_d = i0_last;
            y_sel_d  = SRC_I0;
         end
      end
   end

   // Output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_data_q  <= '0;
         y_valid_q <= 1'b0;
         y_last_q  <= 1'b0;
         y_sel_q   <= SRC_I0;
      end else begin
         y_data_q  <= y_data_d;
         y_valid_q <= y_valid_d;
         y_last_q  <= y_last_d;
         y_sel_q   <= y_sel_d;
      end
   end

   assign y_data  = y_data_q;
   assign y_valid = y_valid_q;
   assign y_last  = y_last_q;
   assign y_sel   = y_sel_q;

endmodule
`default_nettype wire
